sensor_packet_rx: RTL and testbench

SENSOR_PACKET_RX -- requirements
Module: sensor_packet_rx

---
 rtl/sensor_packet_rx_if.sv | 26 ++
 rtl/sensor_packet_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sensor_packet_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sensor_packet_rx_if.sv
// rtl/sensor_packet_rx_if.sv - decoded count / frame status bundle out of sensor_packet_rx
//
// Signals:
//   count_valid  one-cycle strobe, count_tx/count_index/count_value are new
//   count_tx     transmitter index (letter - 'A') of the current line
//   count_index  receiver index within the line, 0..kRxCount-1
//   count_value  decoded 16-bit receiver count
//   frame_ok     one-cycle strobe, a complete well-formed line ended
//   frame_err    one-cycle strobe, malformed line or UART framing error
// Modports: master drives the bundle (the receiver), slave consumes it.
interface sensor_packet_rx_if;
    logic        count_valid;
    logic [3:0]  count_tx;
    logic [4:0]  count_index;
    logic [15:0] count_value;
    logic        frame_ok;
    logic        frame_err;

    modport master (
        output count_valid, count_tx, count_index, count_value, frame_ok, frame_err
    );

    modport slave (
        input count_valid, count_tx, count_index, count_value, frame_ok, frame_err
    );
endinterface

// File: rtl/sensor_packet_rx.sv
// rtl/sensor_packet_rx.sv - 8-N-1 UART receiver plus ASCII hex line parser for sensor counts
//
// Ports:
//   clk     single clock, rising edge
//   rst_n   asynchronous active-low reset
//   rxd     asynchronous serial line, idle level set by kSerialInvert
//   rx_out  sensor_packet_rx_if.master: count strobe/fields, frame_ok, frame_err
//
// A line is one transmitter letter, kRxCount groups of kRxTimerNybbles lowercase
// hex digits, then '\n'. Counts are emitted as soon as their last digit arrives,
// so a consumer must drop the counts of a line that ends in frame_err.
module sensor_packet_rx #(
    parameter int kClockHz        = 25_000_000,
    parameter int kBitClocks      = 28,
    parameter bit kSerialInvert   = 1'b1,
    parameter int kTxCount        = 12,
    parameter int kRxCount        = 20,
    parameter int kRxTimerNybbles = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rxd,
    sensor_packet_rx_if.master rx_out
);

    localparam int CW   = $clog2(kBitClocks);
    localparam int HALF = kBitClocks / 2;
    localparam int VW   = 4 * kRxTimerNybbles;
    localparam int DW   = $clog2(kRxTimerNybbles);
    localparam logic [7:0] LF = 8'h0a;

    // Mid-bit sampling needs a few clocks per bit to land near the bit centre.
    if (kBitClocks < 4 || kClockHz < kBitClocks) begin : g_bad_timing
        $error("sensor_packet_rx: kBitClocks out of range for kClockHz");
    end

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_IDLE, P_HEX, P_EXPECT_NL, P_RESYNC} parse_state_t;

    // ---------------- registers ----------------
    logic          sync1, sync2, line_prev;
    uart_state_t   u_state, u_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    byte_data, byte_data_nxt;
    logic          byte_valid, byte_valid_nxt;
    logic          byte_err, byte_err_nxt;

    parse_state_t  p_state, p_nxt;
    logic [DW-1:0] digit_cnt, digit_cnt_nxt;
    logic [4:0]    idx_cnt, idx_cnt_nxt;
    logic [VW-1:0] acc, acc_nxt;

    logic          cv_q, cv_nxt;
    logic          ok_q, ok_nxt;
    logic          err_q, err_nxt;
    logic [3:0]    tx_q, tx_nxt;
    logic [4:0]    index_q, index_nxt;
    logic [VW-1:0] value_q, value_nxt;

    // Logical line level: 1 = idle/mark after polarity correction.
    logic line;
    assign line = sync2 ^ kSerialInvert;

    // ---------------- byte classification ----------------
    logic          is_letter, is_hex;
    logic [3:0]    nyb;
    logic [VW-1:0] acc_shift;

    always_comb begin
        is_letter = (int'(byte_data) >= 32'h41) && (int'(byte_data) < 32'h41 + kTxCount);
        is_hex    = ((byte_data >= 8'h30) && (byte_data <= 8'h39)) ||
                    ((byte_data >= 8'h61) && (byte_data <= 8'h66));
        // '0'..'9' carry their value in the low nybble; 'a'..'f' are 0x61.. so +9.
        nyb       = (byte_data <= 8'h39) ? byte_data[3:0] : byte_data[3:0] + 4'd9;
        acc_shift = {acc[VW-5:0], nyb};
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        u_nxt          = u_state;
        bit_cnt_nxt    = bit_cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        byte_data_nxt  = byte_data;
        byte_valid_nxt = 1'b0;
        byte_err_nxt   = 1'b0;

        p_nxt          = p_state;
        digit_cnt_nxt  = digit_cnt;
        idx_cnt_nxt    = idx_cnt;
        acc_nxt        = acc;
        cv_nxt         = 1'b0;
        ok_nxt         = 1'b0;
        err_nxt        = 1'b0;
        tx_nxt         = tx_q;
        index_nxt      = index_q;
        value_nxt      = value_q;

        // UART: edge-triggered start so a stuck-low line after a bad stop bit
        // cannot retrigger; the stop sample returns straight to U_IDLE so the
        // next start edge half a bit later is caught with no idle gap.
        case (u_state)
            U_IDLE: begin
                if (line_prev && !line) begin
                    u_nxt       = U_START;
                    bit_cnt_nxt = '0;
                end
            end
            U_START: begin
                if (bit_cnt == CW'(HALF - 1)) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    u_nxt       = line ? U_IDLE : U_DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            U_DATA: begin
                if (bit_cnt == CW'(kBitClocks - 1)) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = {line, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        u_nxt = U_STOP;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            U_STOP: begin
                if (bit_cnt == CW'(kBitClocks - 1)) begin
                    bit_cnt_nxt = '0;
                    u_nxt       = U_IDLE;
                    if (line) begin
                        byte_valid_nxt = 1'b1;
                        byte_data_nxt  = shreg;
                    end else begin
                        byte_err_nxt = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: u_nxt = U_IDLE;
        endcase

        // Parser: consumes the byte strobes registered by the UART above.
        if (byte_err) begin
            // Framing errors while already resyncing are part of the same bad line.
            err_nxt = (p_state != P_RESYNC);
            p_nxt   = P_RESYNC;
        end else if (byte_valid) begin
            case (p_state)
                P_IDLE: begin
                    if (is_letter) begin
                        tx_nxt        = byte_data[3:0] - 4'd1;
                        digit_cnt_nxt = '0;
                        idx_cnt_nxt   = '0;
                        acc_nxt       = '0;
                        p_nxt         = P_HEX;
                    end else if (byte_data != LF) begin
                        err_nxt = 1'b1;
                        p_nxt   = P_RESYNC;
                    end
                end
                P_HEX: begin
                    if (is_hex) begin
                        acc_nxt       = acc_shift;
                        digit_cnt_nxt = digit_cnt + 1'b1;
                        if (digit_cnt == DW'(kRxTimerNybbles - 1)) begin
                            digit_cnt_nxt = '0;
                            cv_nxt        = 1'b1;
                            value_nxt     = acc_shift;
                            index_nxt     = idx_cnt;
                            idx_cnt_nxt   = idx_cnt + 1'b1;
                            if (idx_cnt == 5'(kRxCount - 1)) begin
                                p_nxt = P_EXPECT_NL;
                            end
                        end
                    end else begin
                        err_nxt = 1'b1;
                        p_nxt   = P_RESYNC;
                    end
                end
                P_EXPECT_NL: begin
                    if (byte_data == LF) begin
                        ok_nxt = 1'b1;
                        p_nxt  = P_IDLE;
                    end else begin
                        err_nxt = 1'b1;
                        p_nxt   = P_RESYNC;
                    end
                end
                P_RESYNC: begin
                    if (byte_data == LF) begin
                        p_nxt = P_IDLE;
                    end
                end
                default: p_nxt = P_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= ~kSerialInvert;
            sync2      <= ~kSerialInvert;
            line_prev  <= 1'b1;
            u_state    <= U_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            p_state    <= P_IDLE;
            digit_cnt  <= '0;
            idx_cnt    <= '0;
            acc        <= '0;
            cv_q       <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            tx_q       <= '0;
            index_q    <= '0;
            value_q    <= '0;
        end else begin
            sync1      <= rxd;
            sync2      <= sync1;
            line_prev  <= line;
            u_state    <= u_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_data  <= byte_data_nxt;
            byte_valid <= byte_valid_nxt;
            byte_err   <= byte_err_nxt;
            p_state    <= p_nxt;
            digit_cnt  <= digit_cnt_nxt;
            idx_cnt    <= idx_cnt_nxt;
            acc        <= acc_nxt;
            cv_q       <= cv_nxt;
            ok_q       <= ok_nxt;
            err_q      <= err_nxt;
            tx_q       <= tx_nxt;
            index_q    <= index_nxt;
            value_q    <= value_nxt;
        end
    end

    assign rx_out.count_valid = cv_q;
    assign rx_out.count_tx    = tx_q;
    assign rx_out.count_index = index_q;
    assign rx_out.count_value = value_q;
    assign rx_out.frame_ok    = ok_q;
    assign rx_out.frame_err   = err_q;

endmodule

// File: tb/tb_sensor_packet_rx.sv
// tb/tb_sensor_packet_rx.sv - directed bench for sensor_packet_rx
module tb_sensor_packet_rx;
    localparam int BC = 28;
    localparam logic [7:0] LF = 8'h0a;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b0;

    always #5 clk = ~clk;

    sensor_packet_rx_if bus ();

    sensor_packet_rx #(.kBitClocks(BC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rxd    (rxd),
        .rx_out (bus)
    );

    int total = 0;
    int bad   = 0;

    // Event log filled by the monitor, read by the directed sequence.
    logic [3:0]  q_tx[$];
    logic [4:0]  q_idx[$];
    logic [15:0] q_val[$];
    int n_ok = 0, n_err = 0, n_viol = 0;
    logic p_cv = 1'b0, p_ok = 1'b0, p_err = 1'b0;

    always @(negedge clk) begin
        if (bus.count_valid) begin
            q_tx.push_back(bus.count_tx);
            q_idx.push_back(bus.count_index);
            q_val.push_back(bus.count_value);
        end
        if (bus.frame_ok)  n_ok++;
        if (bus.frame_err) n_err++;
        if (int'(bus.count_valid) + int'(bus.frame_ok) + int'(bus.frame_err) > 1) n_viol++;
        if ((bus.count_valid && p_cv) || (bus.frame_ok && p_ok) || (bus.frame_err && p_err)) n_viol++;
        p_cv  = bus.count_valid;
        p_ok  = bus.frame_ok;
        p_err = bus.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Logical level in, physical level out (line is inverted).
    task automatic send_bit(input logic lvl);
        rxd = ~lvl;
        repeat (BC) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    task automatic send_count(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) send_byte(hexc(v[4*i +: 4]), 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cv"},  32'(bus.count_valid), 0);
        check({tag, "_ok"},  32'(bus.frame_ok),    0);
        check({tag, "_err"}, 32'(bus.frame_err),   0);
        check({tag, "_tx"},  32'(bus.count_tx),    0);
        check({tag, "_idx"}, 32'(bus.count_index), 0);
        check({tag, "_val"}, 32'(bus.count_value), 0);
    endtask

    logic [15:0] exp_v[20];

    task automatic check_fields(input string tag, input int base, input int n, input logic [3:0] tx);
        for (int k = 0; k < n && base + k < q_val.size(); k++) begin
            check({tag, "_tx"},  32'(q_tx[base + k]),  32'(tx));
            check({tag, "_idx"}, 32'(q_idx[base + k]), k);
            check({tag, "_val"}, 32'(q_val[base + k]), 32'(exp_v[k]));
        end
    endtask

    int b_cv, b_ok, b_err;

    task automatic mark();
        b_cv  = q_val.size();
        b_ok  = n_ok;
        b_err = n_err;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2 * BC) @(negedge clk);

        // "C" + counts 0..19 + LF, back to back
        mark();
        send_byte(8'h43, 1'b1);
        for (int n = 0; n < 20; n++) begin
            exp_v[n] = 16'(n);
            send_count(16'(n));
        end
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        check("c_ncount", q_val.size() - b_cv, 20);
        check_fields("c", b_cv, 20, 4'd2);
        check("c_ok", n_ok - b_ok, 1);
        check("c_err", n_err - b_err, 0);

        // "M" is one past the last transmitter: rejected, tail discarded
        mark();
        send_byte(8'h4d, 1'b1);
        send_count(16'h0000);
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        check("m_ncount", q_val.size() - b_cv, 0);
        check("m_ok", n_ok - b_ok, 0);
        check("m_err", n_err - b_err, 1);

        // 'G' as digit 9: two counts, one error, 'A' and hex ignored until LF
        mark();
        send_byte(8'h42, 1'b1);
        send_count(16'h0001);
        send_count(16'h0002);
        send_byte(8'h47, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        exp_v[0] = 16'h0001;
        exp_v[1] = 16'h0002;
        check("g_ncount", q_val.size() - b_cv, 2);
        check_fields("g", b_cv, 2, 4'd1);
        check("g_ok", n_ok - b_ok, 0);
        check("g_err", n_err - b_err, 1);

        // Stop bit low on digit 5
        mark();
        send_byte(8'h44, 1'b1);
        send_count(16'h00ff);
        send_byte(8'h37, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h38, 1'b1);
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        exp_v[0] = 16'h00ff;
        check("s_ncount", q_val.size() - b_cv, 1);
        check_fields("s", b_cv, 1, 4'd3);
        check("s_ok", n_ok - b_ok, 0);
        check("s_err", n_err - b_err, 1);

        // Valid "A" line after the errors, mixed digits including a-f
        mark();
        send_byte(8'h41, 1'b1);
        for (int n = 0; n < 20; n++) begin
            exp_v[n] = 16'h1234 + 16'h1111 * 16'(n);
            send_count(exp_v[n]);
        end
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        check("a_ncount", q_val.size() - b_cv, 20);
        check_fields("a", b_cv, 20, 4'd0);
        check("a_ok", n_ok - b_ok, 1);
        check("a_err", n_err - b_err, 0);

        // Reset after digit 40 of an "E" line
        mark();
        send_byte(8'h45, 1'b1);
        for (int n = 0; n < 10; n++) send_count(16'hab00 + 16'(n));
        repeat (4) @(negedge clk);
        check("e_ncount", q_val.size() - b_cv, 10);
        check("e_tx_before", 32'(bus.count_tx), 4);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);

        // "L" + ffff x20 + LF after reset
        send_byte(8'h4c, 1'b1);
        for (int n = 0; n < 20; n++) begin
            exp_v[n] = 16'hffff;
            send_count(16'hffff);
        end
        send_byte(LF, 1'b1);
        repeat (4) @(negedge clk);
        check("l_ncount", q_val.size() - b_cv, 30);
        check_fields("l", b_cv + 10, 20, 4'd11);
        check("l_ok", n_ok - b_ok, 1);
        check("l_err", n_err - b_err, 0);

        check("strobe_rules", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
